pipeline_run_controller: RTL and testbench
==========================================

// Module: pipeline_run_controller
// PURPOSE
//  Sequences execution of the 5-stage MIPS pipeline for the debug unit: continuous run or single-step.
//  Generates the global stage-enable, a start-of-run flush, fetch stall on HALT and the drain of in-flight instructions.
//  Sits between the debug/UART command decoder and the fetch/decode/execute/memory/writeback register enables.
// PARAMETERS
//  PIPE_DEPTH   5     pipeline stages; drain length after HALT fetch = PIPE_DEPTH-1
//  NB_CYCLES    32    width of the executed-cycle counter
//  MAX_CYCLES   2**20 watchdog limit; used only with RUN_CYCLE_LIMIT_EN
// PORTS
//  i_clk          in   1          system clock, rising edge
//  i_rst_n        in   1          asynchronous reset, active low
//  i_start_cont   in   1          1-cycle pulse: start continuous run (accepted in IDLE only)
//  i_start_step   in   1          1-cycle pulse: start step mode (accepted in IDLE only)
//  i_step         in   1          1-cycle pulse: advance pipeline one cycle (step mode only)
//  i_halt_fetched in   1          fetch stage holds HALT opcode; sampled only when o_pipe_enable=1
//  i_clear        in   1          1-cycle pulse: DONE -> IDLE, counter cleared
//  o_pipe_enable  out  1          enable for all pipeline registers and memories
//  o_fetch_stall  out  1          hold PC/IF-ID input; asserted during DRAIN and DONE
//  o_flush        out  1          synchronous clear of pipeline registers and PC
//  o_done         out  1          program retired; level, held until i_clear
//  o_timeout      out  1          watchdog expiry (tied 0 without RUN_CYCLE_LIMIT_EN)
//  o_state        out  3          current FSM state, for debug readback
//  o_cycle_count  out  NB_CYCLES  number of cycles with o_pipe_enable=1 since last flush
// BEHAVIOUR
//  Reset: state=IDLE, mode=CONT, all outputs 0, drain counter 0, cycle counter 0.
//  States: IDLE(0) FLUSH(1) RUN(2) STEP_WAIT(3) STEP_EXEC(4) DRAIN(5) DONE(6).
//  IDLE: i_start_cont -> FLUSH with mode=CONT; i_start_step -> FLUSH with mode=STEP; both asserted -> CONT wins.
//  FLUSH: exactly 1 cycle; o_flush=1, o_pipe_enable=0, cycle counter cleared; next is RUN (CONT) or STEP_WAIT (STEP).
//  RUN: o_pipe_enable=1 every cycle. i_halt_fetched=1 -> DRAIN, drain counter loaded with PIPE_DEPTH-1.
//  STEP_WAIT: o_pipe_enable=0; i_step -> STEP_EXEC. i_step outside STEP_WAIT/DRAIN(STEP) is ignored.
//  STEP_EXEC: exactly 1 cycle, o_pipe_enable=1; i_halt_fetched=1 -> DRAIN (load PIPE_DEPTH-1), else -> STEP_WAIT.
//  DRAIN: o_fetch_stall=1. In CONT, o_pipe_enable=1 every cycle. In STEP, o_pipe_enable=1 only in the cycle i_step is seen.
//    Each enabled cycle decrements the drain counter; enabled cycle with counter==1 -> DONE.
//    The HALT cycle plus PIPE_DEPTH-1 drain cycles make HALT reach writeback.
//  DONE: o_done=1, o_fetch_stall=1, o_pipe_enable=0; i_clear -> IDLE and clears o_done and o_cycle_count.
//  Outputs are Moore, decoded from registered state (o_pipe_enable in DRAIN/STEP also uses i_step combinationally).
//  Cycle counter: +1 on every cycle with o_pipe_enable=1; saturates at all-ones with no wrap.
//  i_start_* pulses outside IDLE are ignored, so a run cannot restart mid-program.
//  Asynchronous reset mid-run returns to IDLE immediately; no flush is issued until the next start.
// CONFIGURATION
//  RUN_CYCLE_LIMIT_EN defined: in RUN, STEP_EXEC or DRAIN, an enabled cycle that brings o_cycle_count to MAX_CYCLES
//    -> DONE with o_timeout=1; o_timeout is cleared by i_clear.
//  RUN_CYCLE_LIMIT_EN undefined: no watchdog, o_timeout constant 0, MAX_CYCLES unused.
// STRUCTURE
//  Shared header pipeline_defs.vh holds the state encodings (ST_IDLE..ST_DONE), mode encoding and the PIPE_DEPTH default.
//  The debug unit includes the same header to decode o_state.
//  One sub-module: sat_counter (NB-bit saturating up-counter with sync clear and enable), used for o_cycle_count.
//  Drain counter stays inline.
// TESTING
//  Reset, then i_start_cont: one o_flush cycle, then o_pipe_enable=1; HALT at enabled cycle 10 -> o_fetch_stall 4 cycles,
//    o_done=1, o_cycle_count=14.
//  i_start_step then 3 i_step pulses spaced 5 cycles apart: exactly 3 single-cycle o_pipe_enable pulses, o_cycle_count=3, state=STEP_WAIT.
//  Step mode, HALT on step 2, then 4 further i_step pulses: DONE only after the 4th pulse; o_cycle_count=6.
//  i_start_cont and i_start_step in the same cycle -> continuous mode.
//    i_start_step while in RUN -> ignored; state stays RUN.
//  Assert i_rst_n=0 during DRAIN: all outputs 0 asynchronously, state=IDLE.
//    i_clear in DONE -> IDLE with o_cycle_count=0.
//  With RUN_CYCLE_LIMIT_EN and MAX_CYCLES=16, continuous run with no HALT: o_timeout=1 and o_done=1 after 16 enabled cycles.

Source files
------------

// File: rtl/pipeline_run_controller_pkg.sv
// Shared definitions for the pipeline run controller: FSM state encodings
// (also used by the debug unit to decode o_state), run-mode encoding and
// parameter defaults.
package pipeline_run_controller_pkg;

   localparam int unsigned PIPE_DEPTH_DEF = 5;
   localparam int unsigned NB_CYCLES_DEF  = 32;
   localparam int unsigned STATE_W        = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_FLUSH     = 3'd1,
      ST_RUN       = 3'd2,
      ST_STEP_WAIT = 3'd3,
      ST_STEP_EXEC = 3'd4,
      ST_DRAIN     = 3'd5,
      ST_DONE      = 3'd6
   } run_state_e;

   typedef enum logic {
      MODE_CONT = 1'b0,
      MODE_STEP = 1'b1
   } run_mode_e;

endpackage : pipeline_run_controller_pkg

// File: rtl/pipeline_run_controller_sat_counter.sv
// NB-bit saturating up-counter with synchronous clear and count enable.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active low
//   i_clr    synchronous clear (wins over i_en)
//   i_en     count enable
//   o_count  current count, sticks at all-ones
module pipeline_run_controller_sat_counter #(
   parameter int unsigned NB = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [NB-1:0] o_count
);

   // Count up, hold at all-ones rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
      end else if (i_clr) begin
         o_count <= '0;
      end else if (i_en && (o_count != '1)) begin
         o_count <= o_count + NB'(1);
      end
   end

endmodule : pipeline_run_controller_sat_counter

// File: rtl/pipeline_run_controller.sv
// Run/step sequencer for the 5-stage pipeline, driven by the debug command
// decoder. Issues a one-cycle flush at start of run, gates the global stage
// enable (continuous or single-step), stalls fetch once HALT is fetched and
// drains the in-flight instructions before reporting done.
// Optional feature macro: RUN_CYCLE_LIMIT_EN adds a watchdog that ends the
// run with o_timeout=1 once MAX_CYCLES enabled cycles have executed.
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_start_cont     pulse, start continuous run (IDLE only)
//   i_start_step     pulse, start step mode (IDLE only)
//   i_step           pulse, advance one cycle in step mode
//   i_halt_fetched   fetch stage holds HALT (sampled on enabled cycles)
//   i_clear          pulse, DONE -> IDLE and clear the cycle counter
//   o_pipe_enable    enable for all pipeline registers/memories
//   o_fetch_stall    hold PC and IF/ID input (DRAIN, DONE)
//   o_flush          synchronous clear of pipeline registers and PC
//   o_done           program retired, held until i_clear
//   o_timeout        watchdog expiry (0 without RUN_CYCLE_LIMIT_EN)
//   o_state          current FSM state for debug readback
//   o_cycle_count    enabled cycles since last flush, saturating
module pipeline_run_controller
   import pipeline_run_controller_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
`ifdef RUN_CYCLE_LIMIT_EN
   parameter int unsigned MAX_CYCLES = 2**20,
`endif
   parameter int unsigned NB_CYCLES  = NB_CYCLES_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start_cont,
   input  logic                 i_start_step,
   input  logic                 i_step,
   input  logic                 i_halt_fetched,
   input  logic                 i_clear,
   output logic                 o_pipe_enable,
   output logic                 o_fetch_stall,
   output logic                 o_flush,
   output logic                 o_done,
   output logic                 o_timeout,
   output logic [STATE_W-1:0]   o_state,
   output logic [NB_CYCLES-1:0] o_cycle_count
);

   localparam int unsigned DRAIN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);
`ifdef RUN_CYCLE_LIMIT_EN
   localparam logic [NB_CYCLES-1:0] WD_LAST = NB_CYCLES'(MAX_CYCLES - 1);
`endif

   run_state_e         state_q, state_d;
   run_mode_e          mode_q, mode_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               timeout_q, timeout_d;
   logic               pipe_en_c;
   logic               cnt_clr_c;
   logic               wd_hit_c;
   logic               fetch_stall_c;
   logic               flush_c;
   logic               done_c;

   // State, mode, drain counter and timeout flag registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_CONT;
         drain_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         drain_q   <= drain_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and Moore output decode; step-mode drain also gates on i_step.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      drain_d       = drain_q;
      timeout_d     = timeout_q;
      cnt_clr_c     = 1'b0;
      fetch_stall_c = 1'b0;
      flush_c       = 1'b0;
      done_c        = 1'b0;

      pipe_en_c = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC) ||
                  ((state_q == ST_DRAIN) && ((mode_q == MODE_CONT) || i_step));

`ifdef RUN_CYCLE_LIMIT_EN
      // This enabled cycle brings the count up to MAX_CYCLES.
      wd_hit_c = pipe_en_c && (o_cycle_count == WD_LAST);
`else
      wd_hit_c = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (i_start_cont) begin
               state_d = ST_FLUSH;
               mode_d  = MODE_CONT;
            end else if (i_start_step) begin
               state_d = ST_FLUSH;
               mode_d  = MODE_STEP;
            end
         end
         ST_FLUSH: begin
            flush_c   = 1'b1;
            cnt_clr_c = 1'b1;
            state_d   = (mode_q == MODE_CONT) ? ST_RUN : ST_STEP_WAIT;
         end
         ST_RUN: begin
            if (wd_hit_c) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (i_halt_fetched) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         ST_STEP_WAIT: begin
            if (i_step) begin
               state_d = ST_STEP_EXEC;
            end
         end
         ST_STEP_EXEC: begin
            if (wd_hit_c) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (i_halt_fetched) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end else begin
               state_d = ST_STEP_WAIT;
            end
         end
         ST_DRAIN: begin
            fetch_stall_c = 1'b1;
            if (pipe_en_c) begin
               drain_d = drain_q - DRAIN_W'(1);
               if (wd_hit_c) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end else if (drain_q == DRAIN_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            fetch_stall_c = 1'b1;
            done_c        = 1'b1;
            if (i_clear) begin
               state_d   = ST_IDLE;
               cnt_clr_c = 1'b1;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Executed-cycle counter.
   pipeline_run_controller_sat_counter #(
      .NB (NB_CYCLES)
   ) u_cycle_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (cnt_clr_c),
      .i_en    (pipe_en_c),
      .o_count (o_cycle_count)
   );

   assign o_pipe_enable = pipe_en_c;
   assign o_fetch_stall = fetch_stall_c;
   assign o_flush       = flush_c;
   assign o_done        = done_c;
   assign o_timeout     = timeout_q;
   assign o_state       = state_q;

endmodule : pipeline_run_controller

// File: tb/tb_pipeline_run_controller.sv
// Testbench for pipeline_run_controller: table-driven continuous run plus
// hand-written step, drain, priority and reset sequences, and a direct check
// of the saturating counter at a narrow width.
module tb_pipeline_run_controller;
   import pipeline_run_controller_pkg::*;

   localparam int unsigned NB = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_cont = 1'b0;
   logic          start_step = 1'b0;
   logic          step = 1'b0;
   logic          halt_fetched = 1'b0;
   logic          clear = 1'b0;
   logic          pipe_enable;
   logic          fetch_stall;
   logic          flush;
   logic          done;
   logic          timeout;
   logic [2:0]    state;
   logic [NB-1:0] cycle_count;

   logic          sc_clr = 1'b0;
   logic          sc_en = 1'b0;
   logic [2:0]    sc_count;

   always #5 clk = ~clk;

   pipeline_run_controller #(
`ifdef RUN_CYCLE_LIMIT_EN
      .MAX_CYCLES (16),
`endif
      .PIPE_DEPTH (5),
      .NB_CYCLES  (NB)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start_cont   (start_cont),
      .i_start_step   (start_step),
      .i_step         (step),
      .i_halt_fetched (halt_fetched),
      .i_clear        (clear),
      .o_pipe_enable  (pipe_enable),
      .o_fetch_stall  (fetch_stall),
      .o_flush        (flush),
      .o_done         (done),
      .o_timeout      (timeout),
      .o_state        (state),
      .o_cycle_count  (cycle_count)
   );

   pipeline_run_controller_sat_counter #(
      .NB (3)
   ) u_sat (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (sc_clr),
      .i_en    (sc_en),
      .o_count (sc_count)
   );

   typedef struct packed {
      logic [2:0]    st;
      logic          en;
      logic          stall;
      logic          flush;
      logic          done;
      logic          tmo;
      logic [NB-1:0] cnt;
   } obs_t;

   typedef struct {
      logic sc;
      logic ss;
      logic stp;
      logic hlt;
      logic clr;
      obs_t exp;
   } vec_t;

   obs_t  sb[$];
   vec_t  tbl[$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic obs_t ob(input logic [2:0] st, input logic en, input logic stall,
                               input logic fl, input logic dn, input logic [NB-1:0] cnt);
      obs_t o;
      o.st    = st;
      o.en    = en;
      o.stall = stall;
      o.flush = fl;
      o.done  = dn;
      o.tmo   = 1'b0;
      o.cnt   = cnt;
      return o;
   endfunction

   function automatic vec_t mk(input logic sc, input logic ss, input logic stp,
                               input logic hlt, input logic clr, input obs_t e);
      vec_t v;
      v.sc  = sc;
      v.ss  = ss;
      v.stp = stp;
      v.hlt = hlt;
      v.clr = clr;
      v.exp = e;
      return v;
   endfunction

   function automatic obs_t act();
      obs_t o;
      o.st    = state;
      o.en    = pipe_enable;
      o.stall = fetch_stall;
      o.flush = flush;
      o.done  = done;
      o.tmo   = timeout;
      o.cnt   = cycle_count;
      return o;
   endfunction

   // Pop the oldest expectation and compare against the live outputs.
   task automatic check(input string tag);
      obs_t e;
      obs_t a;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         a = act();
         if (a !== e) begin
            n_err++;
            $display("FAIL %s: got st=%0d en=%b stall=%b flush=%b done=%b tmo=%b cnt=%0d, expected st=%0d en=%b stall=%b flush=%b done=%b tmo=%b cnt=%0d",
                     tag, a.st, a.en, a.stall, a.flush, a.done, a.tmo, a.cnt,
                     e.st, e.en, e.stall, e.flush, e.done, e.tmo, e.cnt);
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample 1 ns later.
   task automatic drive(input logic sc, input logic ss, input logic stp, input logic hlt,
                        input logic clr, input obs_t e, input string tag);
      @(negedge clk);
      start_cont   = sc;
      start_step   = ss;
      step         = stp;
      halt_fetched = hlt;
      clear        = clr;
      sb.push_back(e);
      #1;
      check(tag);
   endtask

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Assert reset mid-cycle and expect every output at zero without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      sb.push_back(ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)));
      #1;
      check(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      obs_t e;

      // Continuous run table: flush, 10 run cycles with HALT on the 10th,
      // 4 drain cycles, DONE held, then clear back to IDLE.
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0))));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ob(ST_FLUSH, 1'b0, 1'b0, 1'b1, 1'b0, NB'(0))));
      for (int k = 1; k <= 10; k++) begin
         tbl.push_back(mk(1'b0, (k == 3), 1'b0, (k == 10), (k == 5),
                          ob(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, NB'(k - 1))));
      end
      for (int d = 1; d <= 4; d++) begin
         tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          ob(ST_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0, NB'(9 + d))));
      end
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(14))));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(14))));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(14))));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0))));

      // Reset state.
      #1;
      sb.push_back(ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)));
      check("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].sc, tbl[i].ss, tbl[i].stp, tbl[i].hlt, tbl[i].clr, tbl[i].exp,
               $sformatf("cont[%0d]", i));
      end

      // Step mode: three steps five cycles apart; a stray i_step in STEP_EXEC does nothing.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "step_start");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_FLUSH, 1'b0, 1'b0, 1'b1, 1'b0, NB'(0)), "step_flush");
      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < 3; w++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_STEP_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, NB'(i)),
                  $sformatf("step_wait[%0d.%0d]", i, w));
         end
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ob(ST_STEP_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, NB'(i)),
               $sformatf("step_req[%0d]", i));
         drive(1'b0, 1'b0, (i == 1), 1'b0, 1'b0, ob(ST_STEP_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, NB'(i)),
               $sformatf("step_exec[%0d]", i));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_STEP_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, NB'(3)), "step_end");
      async_reset("rst_step_wait");

      // Step mode, HALT on step 2, drain needs four more steps.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "sh_start");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_FLUSH, 1'b0, 1'b0, 1'b1, 1'b0, NB'(0)), "sh_flush");
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ob(ST_STEP_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "sh_req1");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_STEP_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, NB'(0)), "sh_exec1");
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ob(ST_STEP_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, NB'(1)), "sh_req2");
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ob(ST_STEP_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, NB'(1)), "sh_exec2_halt");
      for (int j = 0; j < 4; j++) begin
         drive(1'b0, 1'b0, 1'b0, (j == 0), 1'b0, ob(ST_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, NB'(2 + j)),
               $sformatf("sh_drain_idle[%0d]", j));
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, NB'(2 + j)),
               $sformatf("sh_drain_hold[%0d]", j));
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ob(ST_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0, NB'(2 + j)),
               $sformatf("sh_drain_step[%0d]", j));
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(6)), "sh_done_start_ign");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(6)), "sh_done_hold");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(6)), "sh_clear");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "sh_idle");

      // Both starts together select continuous mode; reset mid-drain.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "both_start");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_FLUSH, 1'b0, 1'b0, 1'b1, 1'b0, NB'(0)), "both_flush");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, NB'(0)), "both_run0");
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ob(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, NB'(1)), "both_run1_halt");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0, NB'(2)), "both_drain0");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0, NB'(3)), "both_drain1");
      async_reset("rst_drain");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "post_rst0");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "post_rst1");

`ifdef RUN_CYCLE_LIMIT_EN
      // Watchdog: 16 enabled cycles without HALT end the run with timeout.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "wd_start");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_FLUSH, 1'b0, 1'b0, 1'b1, 1'b0, NB'(0)), "wd_flush");
      for (int k = 1; k <= 16; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, NB'(k - 1)),
               $sformatf("wd_run[%0d]", k));
      end
      e = ob(ST_DONE, 1'b0, 1'b1, 1'b0, 1'b1, NB'(16));
      e.tmo = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, "wd_done");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e, "wd_clear");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0)), "wd_idle");
`else
      e = ob(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, NB'(0));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, "idle_final");
`endif

      // Saturating counter at 3 bits: counts, sticks at 7, clear wins over enable.
      @(negedge clk);
      sc_en = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check_val("sat_count5", int'(sc_count), 5);
      repeat (4) @(negedge clk);
      #1;
      check_val("sat_hold7", int'(sc_count), 7);
      sc_clr = 1'b1;
      @(negedge clk);
      #1;
      check_val("sat_clear", int'(sc_count), 0);
      sc_clr = 1'b0;
      sc_en  = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pipeline_run_controller
